// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter.
// Op codes, FSM state encoding and default widths.
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_1.sv
// Combinational one-bit shift step.
// Reserved op passes the operand through unchanged.
module shift_step_1
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;

    assign w_sra = {d[WIDTH-1], d[WIDTH-1:1]};
    assign w_sll = {d[WIDTH-2:0], 1'b0};
    assign w_srl = {1'b0, d[WIDTH-1:1]};

    always_comb begin
        q = d;
        unique case (op)
            OP_SLL:  q = w_sll;
            OP_SRA:  q = w_sra;
            OP_SRL:  q = w_srl;
            OP_RSV:  q = d;
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_iter.sv
// Iterative shifter: one bit position per clock,
// valid/ready in and out, no same-cycle bypass.
module shift_iter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_t           state_r;
    logic [WIDTH-1:0] data_r;
    logic [SHW-1:0]   cnt_r;
    logic [1:0]       op_r;

    state_t           w_state_n;
    logic [WIDTH-1:0] w_data_n;
    logic [SHW-1:0]   w_cnt_n;
    logic [1:0]       w_op_n;
    logic [WIDTH-1:0] w_step;

    shift_step_1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .d  (data_r),
        .op (op_r),
        .q  (w_step)
    );

    always_comb begin
        w_state_n = state_r;
        w_data_n  = data_r;
        w_cnt_n   = cnt_r;
        w_op_n    = op_r;
        unique case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    w_data_n = in_data;
                    w_cnt_n  = in_shamt;
                    w_op_n   = in_op;
                    w_state_n = (in_shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_data_n = w_step;
                w_cnt_n  = cnt_r - SHW'(1);
                // Leave on the last step so the counter stops at zero.
                if (cnt_r == SHW'(1)) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            data_r  <= '0;
            cnt_r   <= '0;
            op_r    <= '0;
        end else begin
            state_r <= w_state_n;
            data_r  <= w_data_n;
            cnt_r   <= w_cnt_n;
            op_r    <= w_op_n;
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign out_data  = data_r;

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter against a
// behavioural shift/latency model.
module tb_shift_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    shift_iter #(.WIDTH(32), .SHW(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] model_res(input logic [31:0] d,
                                              input logic [4:0] sh,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return 32'($signed(d) >>> sh);
            2'b10:   return d >> sh;
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sh);
        return (sh == 5'd0) ? 1 : int'(sh) + 1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one request, measures latency, stalls the consumer, drains.
    task automatic run_op(input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] op, input int stall,
                          output int lat, output logic [31:0] res,
                          output logic stable, output logic rdy_after,
                          output logic vld_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_op    = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = out_data;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (out_valid !== 1'b1 || out_data !== res || in_ready !== 1'b0)
                stable = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rdy_after = in_ready;
        vld_after = out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h want 1 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] td [5];
        logic [4:0]  ts [5];
        logic [1:0]  to [5];
        logic [31:0] te [5];
        int lat;
        logic [31:0] res;
        logic st, ra, va;
        td[0] = 32'h80000000; ts[0] = 5'd4;  to[0] = 2'b01; te[0] = 32'hF8000000;
        td[1] = 32'h00000001; ts[1] = 5'd31; to[1] = 2'b00; te[1] = 32'h80000000;
        td[2] = 32'h80000000; ts[2] = 5'd31; to[2] = 2'b10; te[2] = 32'h00000001;
        td[3] = 32'h12345678; ts[3] = 5'd0;  to[3] = 2'b01; te[3] = 32'h12345678;
        td[4] = 32'hDEADBEEF; ts[4] = 5'd3;  to[4] = 2'b11; te[4] = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            run_op(td[k], ts[k], to[k], 1, lat, res, st, ra, va);
            vectors++;
            if (res !== te[k] || lat != model_lat(ts[k])) begin
                miscompares++;
                $display("FAIL directed[%0d]: data=%h lat=%0d want %h %0d",
                         k, res, lat, te[k], model_lat(ts[k]));
            end
            vectors++;
            if (ra !== 1'b1 || va !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_drain[%0d]: in_ready=%b out_valid=%b want 1 0",
                         k, ra, va);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1;
        in_data  = 32'h7FFFFFFF;
        in_shamt = 5'd1;
        in_op    = 2'b01;
        tick();
        in_data  = 32'h00000001;
        in_shamt = 5'd2;
        in_op    = 2'b00;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_busy: in_ready=%b want 0", in_ready);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'h3FFFFFFF || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h rdy=%b want 1 3fffffff 0",
                         k, out_valid, out_data, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drain: v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        vectors++;
        if (out_data !== 32'h00000004 || lat != 3) begin
            miscompares++;
            $display("FAIL bp_second: data=%h lat=%0d want 00000004 3", out_data, lat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        logic st, ra, va;
        in_valid = 1'b1;
        in_data  = $urandom;
        in_shamt = 5'd20;
        in_op    = 2'b01;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b v=%b d=%h want 1 0 0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        run_op(32'hF0000000, 5'd8, 2'b10, 0, lat, res, st, ra, va);
        vectors++;
        if (res !== 32'h00F00000 || lat != 9) begin
            miscompares++;
            $display("FAIL reset_after: data=%h lat=%0d want 00f00000 9", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, res, exp;
        logic [4:0]  sh;
        logic [1:0]  op;
        int stall, lat;
        logic st, ra, va;
        for (int k = 0; k < 40; k++) begin
            d     = $urandom;
            sh    = 5'($urandom);
            op    = 2'($urandom_range(0, 3));
            stall = $urandom_range(0, 3);
            exp   = model_res(d, sh, op);
            run_op(d, sh, op, stall, lat, res, st, ra, va);
            vectors++;
            if (res !== exp || lat != model_lat(sh) || st !== 1'b1 ||
                ra !== 1'b1 || va !== 1'b0) begin
                miscompares++;
                $display("FAIL random[%0d]: op=%0d sh=%0d d=%h got %h lat=%0d st=%b rdy=%b v=%b want %h lat=%0d st=1 rdy=1 v=0",
                         k, op, sh, d, res, lat, st, ra, va, exp, model_lat(sh));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_prev;
        int n_prev, acc_prev, guard;
        logic seen;
        logic [4:0] sh;
        out_ready = 1'b1;
        acc_prev = 0;
        n_prev = 0;
        exp_prev = '0;
        for (int k = 0; k < 8; k++) begin
            sh = (k == 0) ? 5'd0 : 5'($urandom_range(0, 6));
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = sh;
            in_op    = 2'($urandom_range(0, 3));
            guard = 0;
            seen = 1'b0;
            while (!in_ready && guard < 100) begin
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    vectors++;
                    if (out_data !== exp_prev) begin
                        miscompares++;
                        $display("FAIL b2b_data[%0d]: %h want %h", k, out_data, exp_prev);
                    end
                end
                tick();
                guard++;
            end
            if (k > 0) begin
                vectors++;
                if (!seen) begin
                    miscompares++;
                    $display("FAIL b2b_seen[%0d]: out_valid=0 want 1", k);
                end
            end
            exp_prev = model_res(in_data, in_shamt, in_op);
            tick();
            if (k > 0) begin
                vectors++;
                if (cyc - acc_prev != n_prev + 2) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: %0d want %0d",
                             k, cyc - acc_prev, n_prev + 2);
                end
            end
            acc_prev = cyc;
            n_prev = int'(sh);
        end
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick();
            guard++;
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_prev) begin
            miscompares++;
            $display("FAIL b2b_last: v=%b d=%h want 1 %h", out_valid, out_data, exp_prev);
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
